wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone classic arbiter placed directly downstream of the CPU core. It merges the instruction-fetch master (`if_wb_*`) and the data-memory master (`id_wb_*`) onto the single shared bus that feeds the SRAM/peripheral side. Ownership is held for a whole `cyc` burst. Arbitration is round-robin, or fixed-priority by parameter.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_rr_pick.sv | 21 ++
 rtl/wb_arbiter_2m.sv | 116 +++++++++++
 tb/tb_wb_arbiter_2m.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the core-side bus fabric.
package wb_pkg;

  // Grant state; the encoding is the one-hot owner reported on grant_o.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } wb_grant_e;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = WB_DATA_W / 8;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-input winner picker: round-robin on last_grant, or fixed m0 priority.
module wb_rr_pick #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,   // 0 = m0 won last, 1 = m1 won last
  output logic [1:0] winner
);

  // One-hot winner; ties go to m0 when fixed, else to whoever did not win last.
  always_comb begin
    winner = '0;
    unique case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = ((FIXED_PRIO != 0) || last_grant) ? 2'b01 : 2'b10;
      default: winner = '0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter; ownership held for a whole cyc burst.
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic                    m0_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic                    m1_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [1:0]              grant_o
);

  wb_grant_e  state, state_nxt;
  logic       last_grant;
  logic [1:0] pick;

  wb_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req        ({m1_cyc_i, m0_cyc_i}),
    .last_grant (last_grant),
    .winner     (pick)
  );

  // State register; last_grant remembers the owner of the most recent grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == GNT0 && state != GNT0) last_grant <= 1'b0;
      else if (state_nxt == GNT1 && state != GNT1) last_grant <= 1'b1;
    end
  end

  // Next owner: hold for the burst, hand over directly if the other is waiting.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pick[0])      state_nxt = GNT0;
        else if (pick[1]) state_nxt = GNT1;
        else              state_nxt = IDLE;
      end
      GNT0: begin
        if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus mux from the registered owner; cyc/stb also gated by the owner's live cyc.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    unique case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & m0_cyc_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & m1_cyc_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign grant_o  = state;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: round-robin and fixed-priority instances share stimulus.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic [3:0]  m0_sel, m1_sel;

  logic        rr_a0, rr_a1, rr_cyc, rr_stb, rr_we;
  logic [31:0] rr_d0, rr_d1, rr_adr, rr_sdat;
  logic [3:0]  rr_sel;
  logic [1:0]  rr_gnt;
  logic        fp_a0, fp_a1, fp_cyc, fp_stb, fp_we;
  logic [31:0] fp_d0, fp_d1, fp_adr, fp_sdat;
  logic [3:0]  fp_sel;
  logic [1:0]  fp_gnt;

  int total = 0;
  int bad   = 0;

  // Reference: owner 0 = none, 1 = m0, 2 = m1; last = owner of latest grant.
  int owner [2] = '{0, 0};
  int last  [2] = '{2, 2};

  always #5 clk = ~clk;

  wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(rr_a0), .m0_dat_o(rr_d0),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(rr_a1), .m1_dat_o(rr_d1),
    .s_cyc_o(rr_cyc), .s_stb_o(rr_stb), .s_we_o(rr_we), .s_adr_o(rr_adr),
    .s_dat_o(rr_sdat), .s_sel_o(rr_sel), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .grant_o(rr_gnt)
  );

  wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(fp_a0), .m0_dat_o(fp_d0),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(fp_a1), .m1_dat_o(fp_d1),
    .s_cyc_o(fp_cyc), .s_stb_o(fp_stb), .s_we_o(fp_we), .s_adr_o(fp_adr),
    .s_dat_o(fp_sdat), .s_sel_o(fp_sel), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .grant_o(fp_gnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ownership rules: hold while owner keeps cyc, hand over to a waiter, else tie-break.
  function automatic int next_owner(input int o, input int l, input bit c0,
                                    input bit c1, input bit fixed);
    if (o == 1) return c0 ? 1 : (c1 ? 2 : 0);
    if (o == 2) return c1 ? 2 : (c0 ? 1 : 0);
    if (c0 && c1) return (fixed || l == 2) ? 1 : 2;
    if (c0) return 1;
    if (c1) return 2;
    return 0;
  endfunction

  task automatic check_dut(input int d, input logic [1:0] gnt, input logic cyc,
                           input logic stb, input logic we, input logic [31:0] adr,
                           input logic [31:0] sdat, input logic [3:0] sel,
                           input logic a0, input logic a1,
                           input logic [31:0] d0, input logic [31:0] d1);
    int o;
    string p;
    o = owner[d];
    p = (d == 0) ? "rr" : "fp";
    chk({p, "_grant"}, {30'd0, gnt}, (o == 1) ? 32'd1 : (o == 2) ? 32'd2 : 32'd0);
    chk({p, "_s_cyc"}, {31'd0, cyc}, (o == 1) ? {31'd0, m0_cyc} : (o == 2) ? {31'd0, m1_cyc} : 32'd0);
    chk({p, "_s_stb"}, {31'd0, stb}, (o == 1) ? {31'd0, m0_stb & m0_cyc} :
                                     (o == 2) ? {31'd0, m1_stb & m1_cyc} : 32'd0);
    chk({p, "_s_we"},  {31'd0, we},  (o == 1) ? {31'd0, m0_we} : (o == 2) ? {31'd0, m1_we} : 32'd0);
    chk({p, "_s_adr"}, adr,  (o == 1) ? m0_adr : (o == 2) ? m1_adr : 32'd0);
    chk({p, "_s_dat"}, sdat, (o == 1) ? m0_dat : (o == 2) ? m1_dat : 32'd0);
    chk({p, "_s_sel"}, {28'd0, sel}, (o == 1) ? {28'd0, m0_sel} : (o == 2) ? {28'd0, m1_sel} : 32'd0);
    chk({p, "_m0_ack"}, {31'd0, a0}, (o == 1) ? {31'd0, s_ack} : 32'd0);
    chk({p, "_m1_ack"}, {31'd0, a1}, (o == 2) ? {31'd0, s_ack} : 32'd0);
    chk({p, "_m0_dat"}, d0, s_dat);
    chk({p, "_m1_dat"}, d1, s_dat);
  endtask

  // Check mid-cycle, then advance the model with the inputs sampled at the edge.
  task automatic tick();
    @(negedge clk);
    check_dut(0, rr_gnt, rr_cyc, rr_stb, rr_we, rr_adr, rr_sdat, rr_sel, rr_a0, rr_a1, rr_d0, rr_d1);
    check_dut(1, fp_gnt, fp_cyc, fp_stb, fp_we, fp_adr, fp_sdat, fp_sel, fp_a0, fp_a1, fp_d0, fp_d1);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        owner[d] = 0;
        last[d]  = 2;
      end else begin
        int n;
        n = next_owner(owner[d], last[d], m0_cyc, m1_cyc, d == 1);
        if (n != 0 && n != owner[d]) last[d] = n;
        owner[d] = n;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
    {m0_adr, m0_dat, m1_adr, m1_dat, s_dat} = '0;
    m0_sel = '0;
    m1_sel = '0;
    tick();
    tick();
    chk("reset_grant", {30'd0, rr_gnt}, 32'd0);
    chk("reset_s_cyc", {31'd0, rr_cyc}, 32'd0);
    reset = 1'b0;
    tick();

    // m0 alone reads 0x8000_0010; slave acks two cycles after grant.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h8000_0010;
    chk("t1_pre_grant", {30'd0, rr_gnt}, 32'd0);
    tick();
    chk("t1_grant", {30'd0, rr_gnt}, 32'd1);
    chk("t1_s_adr", rr_adr, 32'h8000_0010);
    tick();
    tick();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    #1;
    chk("t1_m0_ack", {31'd0, rr_a0}, 32'd1);
    chk("t1_m0_dat", rr_d0, 32'hDEAD_BEEF);
    chk("t1_m1_ack", {31'd0, rr_a1}, 32'd0);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    tick();
    chk("t1_release", {30'd0, rr_gnt}, 32'd0);

    // Tie right after reset, handover without gap, next tie back to m0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("t2_first", {30'd0, rr_gnt}, 32'd1);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("t2_handover", {30'd0, rr_gnt}, 32'd2);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    chk("t2_idle", {30'd0, rr_gnt}, 32'd0);
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    chk("t2_tie_m0", {30'd0, rr_gnt}, 32'd1);
    chk("t2_fp_tie_m0", {30'd0, fp_gnt}, 32'd1);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    tick();

    // m1 burst of three beats while m0 waits.
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_ack = 1'b1; s_dat = $urandom;
      #1;
      chk("t4_grant", {30'd0, rr_gnt}, 32'd2);
      chk("t4_m1_ack", {31'd0, rr_a1}, 32'd1);
      chk("t4_m0_ack", {31'd0, rr_a0}, 32'd0);
      tick();
      s_ack = 1'b0;
      tick();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    chk("t4_m0_after", {30'd0, rr_gnt}, 32'd1);

    // m0 write fields pass through during GNT0 and vanish in IDLE.
    m0_we = 1'b1; m0_sel = 4'b0011; m0_dat = 32'h1234_5678;
    #1;
    chk("t5_we",  {31'd0, rr_we}, 32'd1);
    chk("t5_sel", {28'd0, rr_sel}, 32'd3);
    chk("t5_dat", rr_sdat, 32'h1234_5678);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("t5_idle_we",  {31'd0, rr_we}, 32'd0);
    chk("t5_idle_sel", {28'd0, rr_sel}, 32'd0);
    chk("t5_idle_dat", rr_sdat, 32'd0);
    m0_we = 1'b0;

    // Reset while m1 waits for ack; late ack must not reach either master.
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("t6_gnt1", {30'd0, rr_gnt}, 32'd2);
    reset = 1'b1;
    tick();
    chk("t6_grant", {30'd0, rr_gnt}, 32'd0);
    chk("t6_s_cyc", {31'd0, rr_cyc}, 32'd0);
    reset = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b1;
    #1;
    chk("t6_m1_ack", {31'd0, rr_a1}, 32'd0);
    chk("t6_m0_ack", {31'd0, rr_a0}, 32'd0);
    tick();
    s_ack = 1'b0;

    // Random bursts against the reference model.
    for (int i = 0; i < 3000; i++) begin
      m0_cyc = m0_cyc ? ($urandom % 4 != 0) : ($urandom % 2 == 0);
      m1_cyc = m1_cyc ? ($urandom % 4 != 0) : ($urandom % 2 == 0);
      m0_stb = $urandom % 2 == 0;  m1_stb = $urandom % 2 == 0;
      m0_we  = $urandom % 2 == 0;  m1_we  = $urandom % 2 == 0;
      m0_adr = $urandom; m1_adr = $urandom;
      m0_dat = $urandom; m1_dat = $urandom;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      s_ack  = $urandom % 3 == 0;
      s_dat  = $urandom;
      reset  = $urandom % 60 == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
